uart_rx_cfg: RTL

Parametrised UART receiver: the next-generation replacement for the fixed 8N1 receive path. Supports configurable data width, optional odd/even parity and one or two stop bits. Samples each bit at mid-period behind a two-flop input synchroniser, rejects false start bits, and reports framing and parity errors per byte. Presents received words through a one-entry valid/ready holding register with overrun detection and RTS flow control. Sits between the board RXD pin and the command/FIFO logic.

---
 rtl/uart_rx_cfg.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
// The RXD pin passes through a two-flop synchroniser. Each bit is sampled at
// mid-period. A false start bit is rejected. Framing and parity errors are
// reported with each word. Received words sit in a one-entry valid/ready
// holding register that detects overrun and drives RTS flow control.
module uart_rx_cfg #(
    parameter int CLK_PER_BIT = 87,  // clk cycles per bit, >= 4
    parameter int DATA_BITS   = 8,   // 5..9, LSB first
    parameter int PARITY      = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS   = 1    // 1 or 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rts
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // Synchroniser and edge-detect history.
    logic s1_q, s2_q, s3_q;

    // Receive FSM state.
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_q, perr_d;

    // A frame completes in the cycle of the final stop-bit sample.
    logic                   done;
    logic                   done_ferr;

    // Holding register.
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   frame_err_q;
    logic                   parity_err_q;
    logic                   overrun_q;
    logic                   accept;

    // Two-flop synchroniser, plus a third flop that keeps the previous s2 value.
    // NOTE: clocked state always uses non-blocking (<=). Every flop then updates
    // from the values before the edge, so this chain shifts by exactly one stage
    // per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rxd;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // FSM state register. The shift register is reset too, so no X value
    // can reach rx_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state logic: bit timing, sampling and error accumulation.
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        done      = 1'b0;
        done_ferr = ferr_q | ~s2_q;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                stop_d = 1'b0;
                // Only a falling edge starts a frame. A line held low does not.
                if (s3_q && !s2_q) begin
                    state_d = S_START;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    // If the line is high again at mid start bit, it was a glitch.
                    state_d = s2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    // Bits arrive LSB first. After DATA_BITS right shifts the
                    // word sits in the correct bit positions.
                    shift_d = {s2_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_PAR: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    if (PARITY == 1) begin
                        perr_d = ~((^shift_q) ^ s2_q);
                    end else begin
                        perr_d = (^shift_q) ^ s2_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (!s2_q) begin
                        ferr_d = 1'b1;
                    end
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign accept = rx_valid_q & rx_ready;

    // Holding register: load on completion when there is room, otherwise flag overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (accept) begin
                overrun_q <= 1'b0;
            end
            if (done) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= shift_q;
                    frame_err_q  <= done_ferr;
                    parity_err_q <= perr_q;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = (PARITY == 0) ? 1'b0 : parity_err_q;
    assign overrun    = overrun_q;
    assign rts        = ~rx_valid_q;

endmodule
